// File: rtl/psum_accumulator_if.sv
// PE-result input and drain-side valid/ready bus of the partial-sum accumulator.
interface psum_accumulator_if #(
  parameter int N_LANE = 96,
  parameter int DATA_W = 16
);
  localparam int IDX_W = (N_LANE > 1) ? $clog2(N_LANE) : 1;

  logic                           i_pe_finish;
  logic [N_LANE-1:0][DATA_W-1:0]  i_pe_feature;
  logic                           o_valid;
  logic                           i_ready;
  logic signed [DATA_W-1:0]       o_data;
  logic [IDX_W-1:0]               o_idx;

  modport slave (
    input  i_pe_finish, i_pe_feature, i_ready,
    output o_valid, o_data, o_idx
  );

  modport master (
    output i_pe_finish, i_pe_feature, i_ready,
    input  o_valid, o_data, o_idx
  );
endinterface

// File: rtl/psum_accumulator.sv
// Accumulates a job's worth of PE feature vectors per lane with saturation, then
// drains one requantized (ReLU, shift, clamp) lane per accepted handshake.
module psum_accumulator #(
  parameter int N_LANE = 96,
  parameter int DATA_W = 16,
  parameter int ACC_W  = 24
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [3:0]            i_num_tiles,
  input  logic [3:0]            i_shift,
  input  logic                  i_relu_en,
  psum_accumulator_if.slave     bus,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_overrun
);
  localparam int IDX_W = (N_LANE > 1) ? $clog2(N_LANE) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN} state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic signed [ACC_W-1:0] r_acc [N_LANE];
  logic [3:0]              r_num_tiles;
  logic [3:0]              r_tile_cnt;
  logic [3:0]              r_shift;
  logic                    r_relu_en;
  logic [IDX_W-1:0]        r_idx;
  logic                    r_done;
  logic                    r_overrun;

  logic                    w_start;
  logic                    w_tile;
  logic [3:0]              w_tiles_eff;
  logic                    w_last_tile;
  logic                    w_accept;
  logic                    w_last_accept;
  logic signed [ACC_W-1:0] w_sel;
  logic signed [ACC_W-1:0] w_relu;
  logic signed [ACC_W-1:0] w_shifted;
  logic [ACC_W-DATA_W:0]   w_upper;
  logic signed [DATA_W-1:0] w_data;

  // Overflow shows up as disagreement between the two top bits of the widened sum.
  function automatic logic signed [ACC_W-1:0] sat_add(
    input logic signed [ACC_W-1:0]  a,
    input logic        [DATA_W-1:0] b
  );
    logic [ACC_W:0] s;
    s = {a[ACC_W-1], a} + {{(ACC_W+1-DATA_W){b[DATA_W-1]}}, b};
    if (s[ACC_W] != s[ACC_W-1])
      return s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    return s[ACC_W-1:0];
  endfunction

  assign w_start       = (r_state == S_IDLE) && i_start;
  assign w_tile        = (r_state == S_ACCUM) && bus.i_pe_finish;
  assign w_tiles_eff   = (r_num_tiles == 4'd0) ? 4'd1 : r_num_tiles;
  assign w_last_tile   = w_tile && ((r_tile_cnt + 4'd1) == w_tiles_eff);
  assign w_accept      = (r_state == S_DRAIN) && bus.i_ready;
  assign w_last_accept = w_accept && (r_idx == IDX_W'(N_LANE - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start)       w_next = S_ACCUM;
      S_ACCUM: if (w_last_tile)   w_next = S_DRAIN;
      S_DRAIN: if (w_last_accept) w_next = S_IDLE;
      default:                    w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_num_tiles <= '0;
      r_tile_cnt  <= '0;
      r_shift     <= '0;
      r_relu_en   <= 1'b0;
      r_idx       <= '0;
      r_done      <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_done <= w_last_accept;
      if (w_start) begin
        r_num_tiles <= i_num_tiles;
        r_shift     <= i_shift;
        r_relu_en   <= i_relu_en;
        r_tile_cnt  <= '0;
        r_overrun   <= 1'b0;
      end else if ((r_state == S_DRAIN) && bus.i_pe_finish) begin
        r_overrun <= 1'b1;
      end
      if (w_tile) r_tile_cnt <= r_tile_cnt + 4'd1;
      if (w_last_tile)   r_idx <= '0;
      else if (w_accept) r_idx <= w_last_accept ? '0 : r_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int j = 0; j < N_LANE; j++) r_acc[j] <= '0;
    end else if (w_start) begin
      for (int j = 0; j < N_LANE; j++) r_acc[j] <= '0;
    end else if (w_tile) begin
      for (int j = 0; j < N_LANE; j++) r_acc[j] <= sat_add(r_acc[j], bus.i_pe_feature[j]);
    end
  end

  // Clamp is safe when every bit above the output sign bit matches it.
  always_comb begin
    w_sel     = r_acc[r_idx];
    w_relu    = (r_relu_en && w_sel[ACC_W-1]) ? '0 : w_sel;
    w_shifted = w_relu >>> r_shift;
    w_upper   = w_shifted[ACC_W-1:DATA_W-1];
    if ((&w_upper) || !(|w_upper))
      w_data = w_shifted[DATA_W-1:0];
    else
      w_data = w_shifted[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
  end

  assign bus.o_valid = (r_state == S_DRAIN);
  assign bus.o_data  = w_data;
  assign bus.o_idx   = r_idx;
  assign o_busy      = (r_state != S_IDLE);
  assign o_done      = r_done;
  assign o_overrun   = r_overrun;
endmodule

// File: tb/tb_psum_accumulator.sv
// Directed scenario bench for psum_accumulator; inputs change and outputs are
// sampled on the falling clock edge.
module tb_psum_accumulator;
  localparam int N_LANE = 96;
  localparam int DATA_W = 16;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic       i_start;
  logic [3:0] i_num_tiles;
  logic [3:0] i_shift;
  logic       i_relu_en;
  logic       o_busy;
  logic       o_done;
  logic       o_overrun;

  int errors = 0;
  int checks = 0;

  logic [N_LANE-1:0][DATA_W-1:0] feat;
  logic signed [DATA_W-1:0]      exp_d;

  always #5 i_clk = ~i_clk;

  psum_accumulator_if #(.N_LANE(N_LANE), .DATA_W(DATA_W)) bus ();

  psum_accumulator #(.N_LANE(N_LANE), .DATA_W(DATA_W), .ACC_W(24)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_start     (i_start),
    .i_num_tiles (i_num_tiles),
    .i_shift     (i_shift),
    .i_relu_en   (i_relu_en),
    .bus         (bus),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_overrun   (o_overrun)
  );

  task automatic start_job(input logic [3:0] tiles, input logic [3:0] sh, input logic relu);
    i_start     = 1'b1;
    i_num_tiles = tiles;
    i_shift     = sh;
    i_relu_en   = relu;
    @(negedge i_clk);
    i_start = 1'b0;
  endtask

  task automatic send_tile();
    bus.i_pe_feature = feat;
    bus.i_pe_finish  = 1'b1;
    @(negedge i_clk);
    bus.i_pe_finish  = 1'b0;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0; i_start = 1'b0; i_num_tiles = '0; i_shift = '0; i_relu_en = 1'b0;
    bus.i_pe_finish = 1'b0; bus.i_pe_feature = '0; bus.i_ready = 1'b0;
    repeat (2) @(negedge i_clk);
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b want 0", bus.o_valid); end
    checks++; if (bus.o_data !== 16'sd0) begin errors++; $display("[TB] FAIL reset_data: got %0d want 0", bus.o_data); end
    checks++; if (bus.o_idx !== 7'd0) begin errors++; $display("[TB] FAIL reset_idx: got %0d want 0", bus.o_idx); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", o_busy); end
    checks++; if (o_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b want 0", o_done); end
    checks++; if (o_overrun !== 1'b0) begin errors++; $display("[TB] FAIL reset_overrun: got %b want 0", o_overrun); end
    i_rst_n = 1'b1;
    @(negedge i_clk);
    checks++; if (o_busy !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_busy: got %b want 0", o_busy); end
  endtask

  task automatic test_idle_finish();
    for (int j = 0; j < N_LANE; j++) feat[j] = 16'd5;
    send_tile();
    checks++; if (o_busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_finish_busy: got %b want 0", o_busy); end
    checks++; if (o_overrun !== 1'b0) begin errors++; $display("[TB] FAIL idle_finish_overrun: got %b want 0", o_overrun); end
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("[TB] FAIL idle_finish_valid: got %b want 0", bus.o_valid); end
  endtask

  task automatic test_single_tile();
    for (int j = 0; j < N_LANE; j++) feat[j] = 16'(j - 48);
    bus.i_ready = 1'b1;
    start_job(4'd1, 4'd0, 1'b0);
    checks++; if (o_busy !== 1'b1) begin errors++; $display("[TB] FAIL single_busy: got %b want 1", o_busy); end
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_early_valid: got %b want 0", bus.o_valid); end
    send_tile();
    checks++; if (bus.o_valid !== 1'b1) begin errors++; $display("[TB] FAIL single_latency: got %b want 1", bus.o_valid); end
    for (int i = 0; i < N_LANE; i++) begin
      exp_d = 16'(i - 48);
      checks++; if (bus.o_idx !== 7'(i)) begin errors++; $display("[TB] FAIL single_idx: got %0d want %0d", bus.o_idx, i); end
      checks++; if (bus.o_data !== exp_d) begin errors++; $display("[TB] FAIL single_data[%0d]: got %0d want %0d", i, bus.o_data, exp_d); end
      @(negedge i_clk);
    end
    checks++; if (o_done !== 1'b1) begin errors++; $display("[TB] FAIL single_done: got %b want 1", o_done); end
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_valid_drop: got %b want 0", bus.o_valid); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("[TB] FAIL single_idle: got %b want 0", o_busy); end
    @(negedge i_clk);
    checks++; if (o_done !== 1'b0) begin errors++; $display("[TB] FAIL single_done_pulse: got %b want 0", o_done); end
  endtask

  task automatic test_multi_tile_shift();
    for (int j = 0; j < N_LANE; j++) feat[j] = 16'd1000;
    feat[5]  = 16'hFFFB;
    feat[95] = 16'h8000;
    bus.i_ready = 1'b1;
    start_job(4'd3, 4'd2, 1'b0);
    send_tile();
    send_tile();
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("[TB] FAIL multi_early_valid: got %b want 0", bus.o_valid); end
    send_tile();
    for (int i = 0; i < N_LANE; i++) begin
      exp_d = (i == 5) ? -16'sd4 : (i == 95) ? -16'sd24576 : 16'sd750;
      checks++; if (bus.o_data !== exp_d) begin errors++; $display("[TB] FAIL multi_data[%0d]: got %0d want %0d", i, bus.o_data, exp_d); end
      @(negedge i_clk);
    end
    checks++; if (o_done !== 1'b1) begin errors++; $display("[TB] FAIL multi_done: got %b want 1", o_done); end
  endtask

  task automatic test_relu_sat();
    feat = '0;
    feat[0] = 16'hFFFB;
    feat[1] = 16'h7FFF;
    feat[2] = 16'h8000;
    bus.i_ready = 1'b1;
    start_job(4'd2, 4'd0, 1'b1);
    send_tile();
    send_tile();
    for (int i = 0; i < N_LANE; i++) begin
      exp_d = (i == 1) ? 16'sd32767 : 16'sd0;
      checks++; if (bus.o_data !== exp_d) begin errors++; $display("[TB] FAIL relu_data[%0d]: got %0d want %0d", i, bus.o_data, exp_d); end
      @(negedge i_clk);
    end
  endtask

  task automatic test_backpressure();
    int valid_cycles;
    valid_cycles = 0;
    for (int j = 0; j < N_LANE; j++) feat[j] = 16'(j * 100);
    feat[3] = 16'h8000;
    feat[4] = 16'h7FFF;
    bus.i_ready = 1'b1;
    start_job(4'd2, 4'd0, 1'b0);
    send_tile();
    send_tile();
    for (int i = 0; i < N_LANE; i++) begin
      exp_d = (i == 3) ? -16'sd32768 : (i == 4) ? 16'sd32767 : 16'(200 * i);
      if (i == 10) begin
        bus.i_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          if (bus.o_valid === 1'b1) valid_cycles++;
          checks++; if (bus.o_idx !== 7'd10) begin errors++; $display("[TB] FAIL stall_idx: got %0d want 10", bus.o_idx); end
          checks++; if (bus.o_data !== exp_d) begin errors++; $display("[TB] FAIL stall_data: got %0d want %0d", bus.o_data, exp_d); end
          @(negedge i_clk);
        end
        bus.i_ready = 1'b1;
      end
      if (bus.o_valid === 1'b1) valid_cycles++;
      checks++; if (bus.o_idx !== 7'(i)) begin errors++; $display("[TB] FAIL bp_idx: got %0d want %0d", bus.o_idx, i); end
      checks++; if (bus.o_data !== exp_d) begin errors++; $display("[TB] FAIL bp_data[%0d]: got %0d want %0d", i, bus.o_data, exp_d); end
      @(negedge i_clk);
    end
    checks++; if (valid_cycles != 101) begin errors++; $display("[TB] FAIL bp_cycles: got %0d want 101", valid_cycles); end
    checks++; if (o_done !== 1'b1) begin errors++; $display("[TB] FAIL bp_done: got %b want 1", o_done); end
  endtask

  task automatic test_overrun();
    for (int j = 0; j < N_LANE; j++) feat[j] = 16'(j + 1);
    bus.i_ready = 1'b1;
    start_job(4'd1, 4'd0, 1'b0);
    send_tile();
    for (int i = 0; i < N_LANE; i++) begin
      exp_d = 16'(i + 1);
      checks++; if (bus.o_data !== exp_d) begin errors++; $display("[TB] FAIL ovr_data[%0d]: got %0d want %0d", i, bus.o_data, exp_d); end
      if (i == 3) begin
        for (int j = 0; j < N_LANE; j++) bus.i_pe_feature[j] = 16'd999;
        bus.i_pe_finish = 1'b1;
        i_start = 1'b1; i_num_tiles = 4'd5; i_shift = 4'd3;
      end else begin
        bus.i_pe_finish = 1'b0;
        i_start = 1'b0;
      end
      @(negedge i_clk);
    end
    checks++; if (o_overrun !== 1'b1) begin errors++; $display("[TB] FAIL ovr_flag: got %b want 1", o_overrun); end
    checks++; if (o_done !== 1'b1) begin errors++; $display("[TB] FAIL ovr_done: got %b want 1", o_done); end
    @(negedge i_clk);
    checks++; if (o_busy !== 1'b0) begin errors++; $display("[TB] FAIL ovr_no_restart: got %b want 0", o_busy); end
    checks++; if (o_overrun !== 1'b1) begin errors++; $display("[TB] FAIL ovr_sticky: got %b want 1", o_overrun); end
  endtask

  task automatic test_reset_mid_accum();
    for (int j = 0; j < N_LANE; j++) feat[j] = 16'd50;
    bus.i_ready = 1'b1;
    start_job(4'd3, 4'd0, 1'b0);
    checks++; if (o_overrun !== 1'b0) begin errors++; $display("[TB] FAIL start_clears_overrun: got %b want 0", o_overrun); end
    send_tile();
    i_rst_n = 1'b0;
    #1;
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_valid: got %b want 0", bus.o_valid); end
    checks++; if (bus.o_data !== 16'sd0) begin errors++; $display("[TB] FAIL mid_rst_data: got %0d want 0", bus.o_data); end
    checks++; if (bus.o_idx !== 7'd0) begin errors++; $display("[TB] FAIL mid_rst_idx: got %0d want 0", bus.o_idx); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_busy: got %b want 0", o_busy); end
    checks++; if (o_done !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_done: got %b want 0", o_done); end
    checks++; if (o_overrun !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_overrun: got %b want 0", o_overrun); end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    send_tile();
    checks++; if (o_busy !== 1'b0) begin errors++; $display("[TB] FAIL job_lost_busy: got %b want 0", o_busy); end
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("[TB] FAIL job_lost_valid: got %b want 0", bus.o_valid); end
    for (int j = 0; j < N_LANE; j++) feat[j] = 16'd7;
    start_job(4'd1, 4'd0, 1'b0);
    send_tile();
    for (int i = 0; i < N_LANE; i++) begin
      checks++; if (bus.o_data !== 16'sd7) begin errors++; $display("[TB] FAIL post_rst_data[%0d]: got %0d want 7", i, bus.o_data); end
      @(negedge i_clk);
    end
    checks++; if (o_done !== 1'b1) begin errors++; $display("[TB] FAIL post_rst_done: got %b want 1", o_done); end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_idle_finish();
    test_single_tile();
    test_multi_tile_shift();
    test_relu_sat();
    test_backpressure();
    test_overrun();
    test_reset_mid_accum();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/psum_accumulator.md
PSUM_ACCUMULATOR -- requirements
Module: psum_accumulator

Interface
REQ-001 SHALL have parameter N_LANE, default 96, the number of PE output lanes (3 x IA channel count).
REQ-002 SHALL have parameter DATA_W, default 16, the signed bit width of PE outputs and drained results.
REQ-003 SHALL have parameter ACC_W, default 24, the signed bit width of each accumulator.
REQ-004 SHALL have port i_clk, input, 1 bit, the clock.
REQ-005 SHALL have port i_rst_n, input, 1 bit, the reset: asynchronous, active-low.
REQ-006 SHALL have port i_start, input, 1 bit, a one-cycle job start, sampled only in IDLE.
REQ-007 SHALL have port i_num_tiles, input, 4 bits, the number of PE results to accumulate per job (0 treated as 1).
REQ-008 SHALL have port i_shift, input, 4 bits, the requantization arithmetic right-shift amount.
REQ-009 SHALL have port i_relu_en, input, 1 bit, which enables ReLU before shift.
REQ-010 SHALL have port i_pe_finish, input, 1 bit, the PE finish pulse that qualifies i_pe_feature.
REQ-011 SHALL have port i_pe_feature, input, N_LANE x DATA_W signed, the PE output feature vector.
REQ-012 SHALL have port o_valid, output, 1 bit, which marks the drain element as valid.
REQ-013 SHALL have port i_ready, input, 1 bit, the downstream accept signal for the drain element.
REQ-014 SHALL have port o_data, output, DATA_W signed, the requantized result.
REQ-015 SHALL have port o_idx, output, clog2(N_LANE) bits, the lane index of o_data.
REQ-016 SHALL have port o_busy, output, 1 bit, high whenever the state is not IDLE.
REQ-017 SHALL have port o_done, output, 1 bit, a one-cycle pulse after the last element is accepted.
REQ-018 SHALL have port o_overrun, output, 1 bit, a sticky flag set when i_pe_finish arrives in DRAIN; cleared on i_start.

Function
REQ-019 SHALL implement states IDLE, ACCUM and DRAIN, with IDLE as the reset state.
REQ-020 SHALL, in IDLE with i_start=1: latch i_num_tiles, i_shift and i_relu_en; clear all accumulators and the tile counter; clear o_overrun; enter ACCUM next cycle.
REQ-021 SHALL ignore i_start outside IDLE; job parameters stay unchanged.
REQ-022 SHALL ignore i_pe_finish in IDLE, with no state change and no flag.
REQ-023 SHALL, in ACCUM, on each clock edge with i_pe_finish=1: acc[j] <= sat_ACC_W(acc[j] + sign_ext(i_pe_feature[j])) for all j, and increment the tile counter.
REQ-024 SHALL, on the edge that accumulates tile number latched_num_tiles, also transition to DRAIN with drain index 0.
REQ-025 SHALL saturate accumulators to [-2^(ACC_W-1), 2^(ACC_W-1)-1]; they never wrap.
REQ-026 SHALL, in DRAIN, hold o_valid=1 and o_idx=drain index, with o_data=requant(acc[o_idx]).
REQ-027 SHALL compute requant as follows: v = (relu_en and acc<0) ? 0 : acc; v = v >>> shift (arithmetic, truncating toward -inf); saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
REQ-028 SHALL keep o_data and o_idx stable while o_valid=1 and i_ready=0.
REQ-029 SHALL, on o_valid and i_ready, advance the index by 1; on accepting index N_LANE-1, go to IDLE, pulse o_done for one cycle and drop o_valid.
REQ-030 SHALL, when i_pe_finish=1 in DRAIN, discard the data, leave the accumulators untouched and set o_overrun.
REQ-031 SHALL give first-element latency as o_valid high in the cycle after the edge that accumulated the last tile.
REQ-032 SHALL complete a drain with i_ready constantly high in exactly N_LANE cycles.

Reset
REQ-033 SHALL, while i_rst_n=0 at any time including mid-job, force: state IDLE; o_valid=0; o_data=0; o_idx=0; o_busy=0; o_done=0; o_overrun=0; accumulators, tile counter and latched parameters all 0.
REQ-034 SHALL, after reset release, resume accepting only a new i_start; the interrupted job is lost.

Verification
REQ-035 SHALL cover a single tile: num_tiles=1, shift=0, relu=0, feature[j]=j-48, i_ready=1 -> o_data sequence is -48..47 at idx 0..95, and o_done pulses on the cycle after idx 95 is accepted.
REQ-036 SHALL cover multi-tile with shift: num_tiles=3, each feature[j]=1000, shift=2 -> every o_data=750.
REQ-037 SHALL cover ReLU and saturation: num_tiles=2, feature[0]=-5 each tile, feature[1]=32767 each tile, relu=1, shift=0 -> o_data[0]=0 and o_data[1]=32767 (saturated).
REQ-038 SHALL cover backpressure: i_ready low for 5 cycles at idx 10 -> o_idx stays 10 and o_data stays constant; drain totals 101 cycles.
REQ-039 SHALL cover overrun and ignored start: i_pe_finish plus i_start during DRAIN -> o_overrun=1, the drained values are unchanged, and a new job does not start until IDLE.
REQ-040 SHALL cover reset mid-ACCUM: i_rst_n low after tile 1 of 3 -> all outputs 0; a new job with num_tiles=1 and feature=7 drains 7.
